execute_cc_stage: RTL and testbench
===================================

# execute_cc_stage

Execute-stage back end of the pipelined Y86-64 core. It consumes the 64-bit ALU result and signed-overflow flag produced by the execute-stage adder, and maintains the architectural condition-code register (ZF/SF/OF). It evaluates the branch/cmov condition and registers the execute results into the E/M pipeline register with stall/bubble control.

## Interface
- No parameters; data width fixed at 64.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- e_icode  in  4  instruction code in E
- e_ifun  in  4  function code in E
- e_stat  in  3  status of instruction in E
- e_valE  in  64  ALU result (adder sum / logic result)
- e_alu_ovf  in  1  signed overflow from ALU adder
- e_valA  in  64  operand A passthrough
- e_dstE_in  in  4  destination E before cmov gating
- e_dstM  in  4  destination M
- m_exc  in  1  instruction in M has stat ≠ AOK
- w_exc  in  1  instruction in W has stat ≠ AOK
- M_stall  in  1  hold E/M register
- M_bubble  in  1  load NOP into E/M register
- cc  out  3  {ZF,SF,OF} register
- e_cnd  out  1  condition result (combinational)
- e_dstE  out  4  gated dstE (combinational, to forwarding)
- M_icode, M_stat, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  4/3/1/64/64/4/4  E/M register

## Operation
- set_cc = (e_icode==OPQ) & (e_stat==AOK) & ~m_exc & ~w_exc & ~M_stall.
- On set_cc: ZF←(e_valE==0), SF←e_valE[63], OF←e_alu_ovf if e_ifun∈{ADD=0,SUB=1}, else 0.
- e_cnd from current cc register (pre-update), by e_ifun: 0 always=1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=~ZF; 5 ge=~(SF^OF); 6 g=~(SF^OF)&~ZF; 7–15 → 0.
- e_dstE = RNONE(0xF) when e_icode==RRMOVQ(2) and ~e_cnd; else e_dstE_in. ifun 0 is unconditional rrmovq.
- e_cnd is meaningful only for JXX/RRMOVQ. It is passed to M_cnd unmodified for all icodes.
- E/M register update: reset or M_bubble → bubble values; else M_stall → hold; else load e_* (M_dstE loads gated e_dstE).
- M_bubble and M_stall together: bubble wins.
- Bubble values: M_icode=NOP(1), M_stat=AOK(1), M_cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.

## Timing
- Reset values: cc=3'b100 (ZF=1), E/M outputs = bubble values. Reset is checked before all other inputs.
- cc update and E/M load take effect on the same rising edge. New flags are visible to e_cnd one cycle after the OPq sits in E.
- e_cnd and e_dstE: zero-cycle combinational from cc, e_ifun, e_icode.
- Latency E→M: one cycle.
- Exception pending in M or W at the edge: cc unchanged, E/M still loads normally.
- Reset asserted mid-stall: bubble values and cc reset win.
- valE arithmetic is pure passthrough. No width change, no sign extension.

## Structure
- Shared package y86_pkg holds:
  - icode constants (HALT, NOP, RRMOVQ, OPQ, JXX, …)
  - ifun ALU/cond codes
  - stat codes AOK=1, HLT=2, ADR=3, INS=4
  - RNONE=4'hF
  - cc bit indices
- Sub-module cond_eval: combinational, inputs cc[2:0] and ifun[3:0], output cnd.
- Flag logic and the E/M register stay in the top module.

## Test plan
- Reset: hold reset 2 cycles → cc=3'b100, M_icode=1, M_dstE=M_dstM=0xF, M_valE=0.
- OPq: icode=6, ifun=1, valE=0, ovf=0 → next cycle cc=3'b100. Then valE=64'h8000_0000_0000_0000, ovf=1 → cc=3'b011. With cc=011, jl (ifun 2) → e_cnd=0; jle → 0.
- Logic op: ifun=3 (xor), valE=64'hFFFF…FFFF, ovf=1 → cc=3'b010 (OF forced 0).
- cmovne: with ZF=1, icode=2, ifun=4, dstE_in=3 → e_dstE=0xF, M_dstE=0xF next cycle. With ZF=0 → M_dstE=3.
- Exception gating: OPq with valE=5 and m_exc=1 → cc unchanged; repeat with w_exc=1 → unchanged; repeat with e_stat=ADR(3) → unchanged.
- Stall/bubble: load valE=0x1234, then M_stall=1 with a new input for 3 cycles → M_valE holds 0x1234. Then M_stall=M_bubble=1 → bubble values next cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, ifuns, stat codes,
// register ids, condition-code bit positions, E/M bundle.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } em_t;

  localparam em_t EM_BUBBLE = '{
    icode: I_NOP,
    stat:  S_AOK,
    cnd:   1'b0,
    valE:  64'd0,
    valA:  64'd0,
    dstE:  RNONE,
    dstM:  RNONE
  };

endpackage

// File: rtl/cond_eval.sv
// Branch/cmov condition evaluator (combinational).
// Ports: cc {ZF,SF,OF}, ifun condition code -> cnd.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic w_zf;
  logic w_lt;

  assign w_zf = cc[CC_ZF];
  assign w_lt = cc[CC_SF] ^ cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = w_lt | w_zf;
      C_L:     cnd = w_lt;
      C_E:     cnd = w_zf;
      C_NE:    cnd = ~w_zf;
      C_GE:    cnd = ~w_lt;
      C_G:     cnd = ~w_lt & ~w_zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_stage.sv
// Execute back end: condition codes, cond/cmov gating, E/M register.
// Ports: e_* from execute, m_exc/w_exc, M_stall/M_bubble -> cc, e_cnd, e_dstE, M_*.
module execute_cc_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic [2:0]  e_stat,
  input  logic [63:0] e_valE,
  input  logic        e_alu_ovf,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE_in,
  input  logic [3:0]  e_dstM,
  input  logic        m_exc,
  input  logic        w_exc,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [2:0]  cc,
  output logic        e_cnd,
  output logic [3:0]  e_dstE,
  output logic [3:0]  M_icode,
  output logic [2:0]  M_stat,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);

  logic [2:0] r_cc;
  em_t        r_em;
  logic       w_cnd;
  logic       w_set_cc;
  logic       w_of;
  logic [3:0] w_dstE;

  cond_eval u_cond (
    .cc   (r_cc),
    .ifun (e_ifun),
    .cnd  (w_cnd)
  );

  // A failed cmov must not write back; RNONE also hides it from forwarding.
  assign w_dstE = (e_icode == I_RRMOVQ && !w_cnd) ? RNONE : e_dstE_in;

  // Flags freeze while an older instruction is faulting or M is held.
  assign w_set_cc = (e_icode == I_OPQ) && (e_stat == S_AOK)
                  && !m_exc && !w_exc && !M_stall;

  // Overflow is only meaningful for add/sub; logic ops clear OF.
  assign w_of = ((e_ifun == A_ADD) || (e_ifun == A_SUB)) & e_alu_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cc <= CC_RESET;
    end else if (w_set_cc) begin
      r_cc <= {(e_valE == 64'd0), e_valE[63], w_of};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || M_bubble) begin
      r_em <= EM_BUBBLE;
    end else if (!M_stall) begin
      r_em <= '{
        icode: e_icode,
        stat:  e_stat,
        cnd:   w_cnd,
        valE:  e_valE,
        valA:  e_valA,
        dstE:  w_dstE,
        dstM:  e_dstM
      };
    end
  end

  assign cc      = r_cc;
  assign e_cnd   = w_cnd;
  assign e_dstE  = w_dstE;
  assign M_icode = r_em.icode;
  assign M_stat  = r_em.stat;
  assign M_cnd   = r_em.cnd;
  assign M_valE  = r_em.valE;
  assign M_valA  = r_em.valA;
  assign M_dstE  = r_em.dstE;
  assign M_dstM  = r_em.dstM;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Self-checking bench for execute_cc_stage: directed table,
// hand sequences for stall/bubble/reset, random vs reference model.
module tb_execute_cc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode, ifun;
  logic [2:0]  stat;
  logic [63:0] valE, valA;
  logic        ovf;
  logic [3:0]  dstE_in, dstM;
  logic        mexc, wexc, stall, bubble;

  logic [2:0]  cc;
  logic        e_cnd;
  logic [3:0]  e_dstE;
  logic [3:0]  M_icode;
  logic [2:0]  M_stat;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_cc_stage dut (
    .clk       (clk),
    .reset     (reset),
    .e_icode   (icode),
    .e_ifun    (ifun),
    .e_stat    (stat),
    .e_valE    (valE),
    .e_alu_ovf (ovf),
    .e_valA    (valA),
    .e_dstE_in (dstE_in),
    .e_dstM    (dstM),
    .m_exc     (mexc),
    .w_exc     (wexc),
    .M_stall   (stall),
    .M_bubble  (bubble),
    .cc        (cc),
    .e_cnd     (e_cnd),
    .e_dstE    (e_dstE),
    .M_icode   (M_icode),
    .M_stat    (M_stat),
    .M_cnd     (M_cnd),
    .M_valE    (M_valE),
    .M_valA    (M_valA),
    .M_dstE    (M_dstE),
    .M_dstM    (M_dstM)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mreg_t;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [2:0]  stat;
    logic [63:0] valE;
    logic        ovf;
    logic [3:0]  dstE_in;
    logic        mexc;
    logic        wexc;
    logic        exp_cnd;
    logic [3:0]  exp_dstE;
    logic [2:0]  exp_cc;
  } vec_t;

  mreg_t BUB = '{4'h1, 3'd1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
  logic [2:0] mcc;
  mreg_t      mm;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  // Condition semantics: "less" means sign disagrees with overflow.
  function automatic logic ref_cond(logic [2:0] c, logic [3:0] f);
    bit zf, lt;
    zf = c[2];
    lt = (c[1] != c[0]);
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply();
    logic       c;
    logic [3:0] de;
    logic [2:0] ncc;
    mreg_t      nm;
    #1;
    c  = ref_cond(mcc, ifun);
    de = (icode == 4'h2 && !c) ? 4'hF : dstE_in;
    chk("e_cnd", e_cnd, c);
    chk("e_dstE", e_dstE, de);
    ncc = mcc;
    nm  = mm;
    if (reset) begin
      ncc = 3'b100;
      nm  = BUB;
    end else begin
      if (icode == 4'h6 && stat == 3'd1 && !mexc && !wexc && !stall)
        ncc = {valE == 64'd0, $signed(valE) < 0,
               (ifun < 4'd2) ? ovf : 1'b0};
      if (bubble) nm = BUB;
      else if (!stall) nm = '{icode, stat, c, valE, valA, de, dstM};
    end
    @(posedge clk);
    #1;
    mcc = ncc;
    mm  = nm;
    chk("cc", cc, mcc);
    chk("M_icode", M_icode, mm.icode);
    chk("M_stat", M_stat, mm.stat);
    chk("M_cnd", M_cnd, mm.cnd);
    chk("M_valE", M_valE, mm.valE);
    chk("M_valA", M_valA, mm.valA);
    chk("M_dstE", M_dstE, mm.dstE);
    chk("M_dstM", M_dstM, mm.dstM);
  endtask

  function automatic vec_t mk(logic [3:0] ic, logic [3:0] fn,
      logic [2:0] st, logic [63:0] ve, logic ov, logic [3:0] di,
      logic me, logic we, logic ec, logic [3:0] ed, logic [2:0] ecc);
    vec_t v;
    v = '{ic, fn, st, ve, ov, di, me, we, ec, ed, ecc};
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(6, 1, 1, 64'd0, 0, 2, 0, 0, 1, 2, 3'b100);
    tbl[1]  = mk(6, 1, 1, 64'h8000_0000_0000_0000, 1, 2, 0, 0, 1, 2, 3'b011);
    tbl[2]  = mk(7, 2, 1, 64'd0, 0, 2, 0, 0, 0, 2, 3'b011);
    tbl[3]  = mk(7, 1, 1, 64'd0, 0, 2, 0, 0, 0, 2, 3'b011);
    tbl[4]  = mk(6, 3, 1, '1, 1, 2, 0, 0, 0, 2, 3'b010);
    tbl[5]  = mk(6, 0, 1, 64'd5, 0, 2, 1, 0, 1, 2, 3'b010);
    tbl[6]  = mk(6, 0, 1, 64'd5, 0, 2, 0, 1, 1, 2, 3'b010);
    tbl[7]  = mk(6, 0, 3, 64'd5, 0, 2, 0, 0, 1, 2, 3'b010);
    tbl[8]  = mk(6, 2, 1, 64'd0, 0, 2, 0, 0, 1, 2, 3'b100);
    tbl[9]  = mk(2, 4, 1, 64'h99, 0, 3, 0, 0, 0, 4'hF, 3'b100);
    tbl[10] = mk(6, 1, 1, 64'd7, 0, 2, 0, 0, 1, 2, 3'b000);
    tbl[11] = mk(2, 4, 1, 64'h99, 0, 3, 0, 0, 1, 3, 3'b000);
    tbl[12] = mk(2, 0, 1, 64'h77, 0, 3, 0, 0, 1, 3, 3'b000);

    mcc = 3'b100;
    mm  = BUB;
    reset = 1'b1;
    icode = 4'h1; ifun = 0; stat = 3'd1; valE = 0; valA = 0;
    ovf = 0; dstE_in = 4'hF; dstM = 4'hF;
    mexc = 0; wexc = 0; stall = 0; bubble = 0;

    // Reset: first edge settles state, second is model-checked.
    @(posedge clk);
    #1;
    apply();
    chk("rst_cc", cc, 3'b100);
    chk("rst_M_icode", M_icode, 4'h1);
    chk("rst_M_dstE", M_dstE, 4'hF);
    chk("rst_M_dstM", M_dstM, 4'hF);
    chk("rst_M_valE", M_valE, 64'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      icode   = tbl[i].icode;
      ifun    = tbl[i].ifun;
      stat    = tbl[i].stat;
      valE    = tbl[i].valE;
      ovf     = tbl[i].ovf;
      dstE_in = tbl[i].dstE_in;
      mexc    = tbl[i].mexc;
      wexc    = tbl[i].wexc;
      valA    = 64'hA000 + 64'(i);
      dstM    = 4'h4;
      #1;
      chk($sformatf("tbl%0d_cnd", i), e_cnd, tbl[i].exp_cnd);
      chk($sformatf("tbl%0d_dstE", i), e_dstE, tbl[i].exp_dstE);
      apply();
      chk($sformatf("tbl%0d_cc", i), cc, tbl[i].exp_cc);
      chk($sformatf("tbl%0d_MvalE", i), M_valE, tbl[i].valE);
      chk($sformatf("tbl%0d_MdstE", i), M_dstE, tbl[i].exp_dstE);
    end
    mexc = 0; wexc = 0;

    // Stall holds E/M and freezes cc; bubble overrides stall.
    icode = 4'h0; ifun = 0; stat = 3'd1; valE = 64'h1234;
    apply();
    chk("ld_MvalE", M_valE, 64'h1234);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      icode = 4'h6; ifun = 0; valE = 64'd0;
      valA = 64'(k);
      apply();
      chk("stall_MvalE", M_valE, 64'h1234);
      chk("stall_cc", cc, 3'b000);
    end
    bubble = 1'b1;
    apply();
    chk("bub_M_icode", M_icode, 4'h1);
    chk("bub_M_valE", M_valE, 64'd0);
    chk("bub_M_dstE", M_dstE, 4'hF);
    stall = 0; bubble = 0;

    // Reset during a stall still clears cc and E/M.
    icode = 4'h6; ifun = 1; valE = 64'h8000_0000_0000_0000; ovf = 1;
    apply();
    chk("pre_rst_cc", cc, 3'b011);
    stall = 1; reset = 1;
    apply();
    chk("rst_stall_cc", cc, 3'b100);
    chk("rst_stall_icode", M_icode, 4'h1);
    chk("rst_stall_valE", M_valE, 64'd0);
    stall = 0; reset = 0;

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0, 1: icode = 4'h6;
        2:    icode = 4'h2;
        default: icode = 4'($urandom_range(0, 15));
      endcase
      ifun    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15))
                                            : 4'($urandom_range(0, 6));
      stat    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      valE    = ($urandom_range(0, 3) == 0) ? 64'd0
                                            : {$urandom, $urandom};
      valA    = {$urandom, $urandom};
      ovf     = 1'($urandom);
      dstE_in = 4'($urandom);
      dstM    = 4'($urandom);
      mexc    = ($urandom_range(0, 9) == 0);
      wexc    = ($urandom_range(0, 9) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      bubble  = ($urandom_range(0, 11) == 0);
      reset   = ($urandom_range(0, 49) == 0);
      apply();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
